// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer/counter block.
package timer_pkg;

   // Default width of the counter, compare and period values.
   localparam int CNT_W_DEF = 16;

   // Counting modes, encoded to match the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_FREE    = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_DOWN    = 2'b11
   } mode_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage : timer_pkg

// File: rtl/timer_counter.sv
// Timer/counter with four counting modes, compare match, sticky flags and
// an interrupt request.
//
// Handshake: clk_pulse is a one-cycle strobe with no back-pressure; every
// strobe seen in RUN with enable high is consumed (or dropped if load is
// high in the same cycle). load/ovf_clr/cmp_clr are likewise single-cycle
// strobes acted on at the next rising edge.
module timer_counter
   import timer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_pulse,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] compare,
   input  logic             ovf_clr,
   input  logic             cmp_clr,
   input  logic             ovf_ie,
   input  logic             cmp_ie,
   output logic [CNT_W-1:0] count,
   output logic             ovf_flag,
   output logic             cmp_flag,
   output logic             cmp_out,
   output logic             running,
   output logic             irq,
   output state_e           fsm_state
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             cmp_q, cmp_d;
   logic             cmp_out_q, cmp_out_d;

   logic [CNT_W-1:0] cnt_next;
   logic             wrap_evt;
   logic             term_evt;
   logic             count_pulse;
   logic             ovf_set;
   logic             cmp_hit;

   // A pulse counts only in RUN with enable held; load steals the cycle.
   assign count_pulse = (state_q == ST_RUN) && enable && clk_pulse && !load;

   // Candidate next count and wrap/terminal detection for the latched mode.
   always_comb begin
      cnt_next = count_q;
      wrap_evt = 1'b0;
      term_evt = 1'b0;
      case (mode_q)
         MODE_FREE: begin
            cnt_next = count_q + CNT_W'(1);
            wrap_evt = (count_q == {CNT_W{1'b1}});
         end
         MODE_RELOAD: begin
            if (count_q == period) begin
               cnt_next = '0;
               wrap_evt = 1'b1;
            end else begin
               cnt_next = count_q + CNT_W'(1);
            end
         end
         MODE_ONESHOT: begin
            if (count_q == period) begin
               cnt_next = count_q;
               wrap_evt = 1'b1;
               term_evt = 1'b1;
            end else begin
               cnt_next = count_q + CNT_W'(1);
            end
         end
         MODE_DOWN: begin
            if (count_q == '0) begin
               cnt_next = period;
               wrap_evt = 1'b1;
            end else begin
               cnt_next = count_q - CNT_W'(1);
            end
         end
         default: begin
            cnt_next = count_q;
         end
      endcase
   end

   assign ovf_set = count_pulse && wrap_evt;
   assign cmp_hit = count_pulse && (cnt_next == compare);

   // FSM next state; mode is captured only when leaving IDLE.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
               mode_d  = mode_e'(mode);
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (count_pulse && term_evt) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next values: load overrides counting, flag set beats clear.
   always_comb begin
      count_d   = count_q;
      ovf_d     = ovf_q;
      cmp_d     = cmp_q;
      cmp_out_d = cmp_out_q;
      if (load) begin
         count_d = load_value;
      end else if (count_pulse) begin
         count_d = cnt_next;
      end
      ovf_d = ovf_set | (ovf_q & ~ovf_clr);
      cmp_d = cmp_hit | (cmp_q & ~cmp_clr);
      if (cmp_hit) begin
         cmp_out_d = ~cmp_out_q;
      end
   end

   // State register; synchronous reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_FREE;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         cmp_q     <= 1'b0;
         cmp_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         cmp_q     <= cmp_d;
         cmp_out_q <= cmp_out_d;
      end
   end

   assign count     = count_q;
   assign ovf_flag  = ovf_q;
   assign cmp_flag  = cmp_q;
   assign cmp_out   = cmp_out_q;
   assign running   = (state_q == ST_RUN);
   assign irq       = (ovf_q & ovf_ie) | (cmp_q & cmp_ie);
   assign fsm_state = state_q;

endmodule : timer_counter

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reload, oneshot, down, free-run wrap,
// load/pulse and set/clear priority, and mid-run reset.
module tb_timer_counter;
   import timer_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_pulse;
   logic         enable;
   logic [1:0]   mode;
   logic         load;
   logic [W-1:0] load_value;
   logic [W-1:0] period;
   logic [W-1:0] compare;
   logic         ovf_clr;
   logic         cmp_clr;
   logic         ovf_ie;
   logic         cmp_ie;
   logic [W-1:0] count;
   logic         ovf_flag;
   logic         cmp_flag;
   logic         cmp_out;
   logic         running;
   logic         irq;
   state_e       fsm_state;

   int checks = 0;
   int errors = 0;

   timer_counter #(.CNT_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_pulse  (clk_pulse),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_value (load_value),
      .period     (period),
      .compare    (compare),
      .ovf_clr    (ovf_clr),
      .cmp_clr    (cmp_clr),
      .ovf_ie     (ovf_ie),
      .cmp_ie     (cmp_ie),
      .count      (count),
      .ovf_flag   (ovf_flag),
      .cmp_flag   (cmp_flag),
      .cmp_out    (cmp_out),
      .running    (running),
      .irq        (irq),
      .fsm_state  (fsm_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed stimulus with hand-computed expectations.
   initial begin
      rst = 1'b1; clk_pulse = 1'b0; enable = 1'b0; mode = 2'b00;
      load = 1'b0; load_value = '0; period = '0; compare = 16'hFFFF;
      ovf_clr = 1'b0; cmp_clr = 1'b0; ovf_ie = 1'b0; cmp_ie = 1'b0;
      step(); step();
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ovf", 32'(ovf_flag), 32'h0);
      chk("rst_cmp", 32'(cmp_flag), 32'h0);
      chk("rst_cmp_out", 32'(cmp_out), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      rst = 1'b0;

      // RELOAD, period 3
      mode = 2'b01; period = 16'd3; enable = 1'b1;
      step();
      chk("rl_running", 32'(running), 32'h1);
      chk("rl_count0", 32'(count), 32'h0);
      clk_pulse = 1'b1;
      step(); chk("rl_count1", 32'(count), 32'h1);
      step(); chk("rl_count2", 32'(count), 32'h2);
      step(); chk("rl_count3", 32'(count), 32'h3);
      chk("rl_ovf_pre", 32'(ovf_flag), 32'h0);
      step(); chk("rl_count_wrap", 32'(count), 32'h0);
      chk("rl_ovf", 32'(ovf_flag), 32'h1);
      chk("rl_irq_masked", 32'(irq), 32'h0);
      clk_pulse = 1'b0; ovf_ie = 1'b1;
      step(); chk("rl_irq_en", 32'(irq), 32'h1);
      ovf_clr = 1'b1;
      step(); chk("rl_ovf_clr", 32'(ovf_flag), 32'h0);
      chk("rl_irq_clr", 32'(irq), 32'h0);
      ovf_clr = 1'b0; clk_pulse = 1'b1;
      step(); chk("rl_count_again", 32'(count), 32'h1);
      enable = 1'b0; clk_pulse = 1'b0;
      step(); chk("rl_idle", 32'(fsm_state), 32'(ST_IDLE));
      chk("rl_hold", 32'(count), 32'h1);

      // ONESHOT, period 2; mode input changed mid-run must be ignored
      load = 1'b1; load_value = 16'd0;
      step(); chk("os_load0", 32'(count), 32'h0);
      load = 1'b0; mode = 2'b10; period = 16'd2; enable = 1'b1;
      step(); chk("os_run", 32'(running), 32'h1);
      clk_pulse = 1'b1;
      step(); chk("os_count1", 32'(count), 32'h1);
      mode = 2'b00;
      step(); chk("os_count2", 32'(count), 32'h2);
      step(); chk("os_term_count", 32'(count), 32'h2);
      chk("os_done", 32'(fsm_state), 32'(ST_DONE));
      chk("os_running", 32'(running), 32'h0);
      chk("os_ovf", 32'(ovf_flag), 32'h1);
      step(); chk("os_extra", 32'(count), 32'h2);
      enable = 1'b0; clk_pulse = 1'b0; ovf_clr = 1'b1;
      step(); chk("os_idle", 32'(fsm_state), 32'(ST_IDLE));
      chk("os_ovf_clr", 32'(ovf_flag), 32'h0);
      ovf_clr = 1'b0;

      // DOWN, load 1, period 5
      load = 1'b1; load_value = 16'd1; mode = 2'b11; period = 16'd5; enable = 1'b1;
      step(); chk("dn_load", 32'(count), 32'h1);
      chk("dn_run", 32'(running), 32'h1);
      load = 1'b0; clk_pulse = 1'b1;
      step(); chk("dn_count0", 32'(count), 32'h0);
      chk("dn_ovf_pre", 32'(ovf_flag), 32'h0);
      step(); chk("dn_reload", 32'(count), 32'h5);
      chk("dn_ovf", 32'(ovf_flag), 32'h1);
      step(); chk("dn_count4", 32'(count), 32'h4);
      enable = 1'b0; clk_pulse = 1'b0; ovf_clr = 1'b1;
      step(); chk("dn_idle", 32'(fsm_state), 32'(ST_IDLE));
      ovf_clr = 1'b0;

      // FREE, compare at top of range, then wrap
      mode = 2'b00; load = 1'b1; load_value = 16'hFFFE; compare = 16'hFFFF;
      enable = 1'b1; ovf_ie = 1'b0; cmp_ie = 1'b1;
      step(); chk("fr_load", 32'(count), 32'hFFFE);
      chk("fr_irq_pre", 32'(irq), 32'h0);
      load = 1'b0; clk_pulse = 1'b1;
      step(); chk("fr_count_max", 32'(count), 32'hFFFF);
      chk("fr_cmp", 32'(cmp_flag), 32'h1);
      chk("fr_cmp_out", 32'(cmp_out), 32'h1);
      chk("fr_irq_cmp", 32'(irq), 32'h1);
      chk("fr_ovf_pre", 32'(ovf_flag), 32'h0);
      step(); chk("fr_wrap", 32'(count), 32'h0);
      chk("fr_ovf", 32'(ovf_flag), 32'h1);
      chk("fr_cmp_out_hold", 32'(cmp_out), 32'h1);

      // load beats a same-cycle pulse; loads never match compare
      load = 1'b1; load_value = 16'd7;
      step(); chk("ld_pulse", 32'(count), 32'h7);
      chk("ld_ovf_keep", 32'(ovf_flag), 32'h1);
      load_value = 16'hFFFF; clk_pulse = 1'b0; ovf_clr = 1'b1; cmp_clr = 1'b1;
      step(); chk("ld_max", 32'(count), 32'hFFFF);
      chk("ld_no_match", 32'(cmp_flag), 32'h0);
      chk("ld_ovf_clr", 32'(ovf_flag), 32'h0);
      chk("ld_cmp_out", 32'(cmp_out), 32'h1);
      load = 1'b0; cmp_clr = 1'b0; clk_pulse = 1'b1;
      step(); chk("setclr_count", 32'(count), 32'h0);
      chk("setclr_ovf", 32'(ovf_flag), 32'h1);

      // reset mid-run overrides load, pulse and clear
      clk_pulse = 1'b0; ovf_clr = 1'b0; load = 1'b1; load_value = 16'h12;
      ovf_ie = 1'b1;
      step(); chk("mr_count", 32'(count), 32'h12);
      chk("mr_irq_pre", 32'(irq), 32'h1);
      rst = 1'b1; load_value = 16'h5; clk_pulse = 1'b1; ovf_clr = 1'b1;
      step();
      chk("mr_count_rst", 32'(count), 32'h0);
      chk("mr_ovf_rst", 32'(ovf_flag), 32'h0);
      chk("mr_cmp_rst", 32'(cmp_flag), 32'h0);
      chk("mr_cmp_out_rst", 32'(cmp_out), 32'h0);
      chk("mr_running_rst", 32'(running), 32'h0);
      chk("mr_irq_rst", 32'(irq), 32'h0);
      chk("mr_state_rst", 32'(fsm_state), 32'(ST_IDLE));

      // RELOAD with period 0: every pulse overflows, count stays 0
      rst = 1'b0; load = 1'b0; ovf_clr = 1'b0; clk_pulse = 1'b0;
      mode = 2'b01; period = 16'd0; compare = 16'hFFFF;
      step(); chk("p0_run", 32'(running), 32'h1);
      clk_pulse = 1'b1;
      step(); chk("p0_count", 32'(count), 32'h0);
      chk("p0_ovf", 32'(ovf_flag), 32'h1);
      clk_pulse = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_timer_counter

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter CNT_W, default 16, counter/compare/period width.
REQ-002 clk  in  1  single block clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 clk_pulse  in  1  one-cycle count-enable strobe from the prescaled input stage.
REQ-005 enable  in  1  run request; 1 = count, 0 = hold.
REQ-006 mode  in  2  00 FREE up, 01 RELOAD up, 10 ONESHOT up, 11 DOWN reload.
REQ-007 load  in  1  synchronous load of count from load_value.
REQ-008 load_value  in  CNT_W  value loaded by load.
REQ-009 period  in  CNT_W  terminal value (RELOAD/ONESHOT); reload value (DOWN).
REQ-010 compare  in  CNT_W  match value.
REQ-011 ovf_clr, cmp_clr  in  1 each  clear strobes for the sticky flags.
REQ-012 ovf_ie, cmp_ie  in  1 each  interrupt enables.
REQ-013 count  out  CNT_W  current counter value, registered.
REQ-014 ovf_flag, cmp_flag  out  1 each  sticky event flags, registered.
REQ-015 cmp_out  out  1  toggles on every compare match, registered.
REQ-016 running  out  1  high while FSM is in RUN.
REQ-017 irq  out  1  (ovf_flag & ovf_ie) | (cmp_flag & cmp_ie), combinational from registers.

Function
REQ-018 FSM states IDLE, RUN, DONE; the FSM SHALL start in IDLE.
REQ-019 IDLE->RUN when enable=1; mode SHALL be latched on this transition and SHALL be ignored while in RUN or DONE.
REQ-020 RUN->IDLE when enable=0; count SHALL hold its value.
REQ-021 RUN->DONE on the ONESHOT terminal event; DONE->IDLE when enable=0.
REQ-022 Count SHALL change only in RUN on a cycle with clk_pulse=1; the new value SHALL be visible the following cycle (1-cycle latency).
REQ-023 FREE: count+1, wrapping 2^CNT_W-1 -> 0 with ovf_flag set.
REQ-024 RELOAD: on a pulse with count==period, count -> 0 and ovf_flag set; otherwise count+1. With period=0, every pulse sets ovf_flag and count stays 0.
REQ-025 ONESHOT: on a pulse with count==period, count holds at period, ovf_flag sets and the FSM enters DONE; further pulses are ignored.
REQ-026 DOWN: on a pulse with count==0, count -> period and ovf_flag set; otherwise count-1.
REQ-027 A counting pulse whose next count equals compare SHALL set cmp_flag and toggle cmp_out in the same update; load SHALL NOT generate a match.
REQ-028 load=1 SHALL set count=load_value next cycle in any state, SHALL win over a simultaneous pulse (that pulse is dropped), and SHALL NOT change flags or FSM state.
REQ-029 Set SHALL win over a same-cycle clear for each flag; otherwise a clear strobe SHALL zero its flag next cycle.
REQ-030 Counter arithmetic SHALL be modulo 2^CNT_W with no carry output beyond ovf_flag.

Reset
REQ-031 rst=1 SHALL drive state=IDLE, count=0, ovf_flag=0, cmp_flag=0, cmp_out=0, running=0, irq=0 and the latched mode to FREE on the next clk edge.
REQ-032 rst SHALL override load, pulse and clear inputs, including mid-count and in DONE.

Structure
REQ-033 Package timer_pkg SHALL hold the mode enum, the FSM state enum and the CNT_W default; timer_counter imports it.
REQ-034 Single module; no sub-module is required.

Verification
REQ-035 RELOAD, period=3, pulse every cycle -> count 0,1,2,3,0; ovf_flag set on the 3->0 update; irq=1 only when ovf_ie=1.
REQ-036 ONESHOT, period=2 -> count 0,1,2 then DONE, running=0; extra pulses leave count=2; enable=0 -> IDLE.
REQ-037 DOWN, load_value=1, period=5 -> count 1,0,5,4; ovf_flag on the 0->5 update.
REQ-038 FREE, load 0xFFFE, compare=0xFFFF -> cmp_flag and cmp_out toggle on reaching 0xFFFF; next pulse wraps to 0 and sets ovf_flag.
REQ-039 load and clk_pulse in the same cycle with load_value=7 -> count=7 (no increment); ovf_clr in the same cycle as an ovf event -> ovf_flag stays 1.
REQ-040 rst asserted mid-RUN with count=0x12 -> next cycle every output is at its REQ-031 reset value.
